// File: rtl/seq_dp_loader.sv
// Sequence duty/phase loader: fetches one frame of (duty,phase) pairs from BRAM
// into a shadow buffer and commits it to the outputs atomically in one edge.
module seq_dp_loader #(
  parameter  int TRANS_NUM  = 249,
  parameter  int LANES      = 4,
  parameter  int IDX_W      = 16,
  parameter  int RD_LATENCY = 2,
  localparam int W          = (TRANS_NUM + LANES - 1) / LANES,
  localparam int S          = $clog2(W),
  localparam int ADDR_W     = IDX_W + S
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENABLE,
  input  logic                    MODE,
  input  logic [7:0]              DUTY_FIXED,
  input  logic [IDX_W-1:0]        SEQ_IDX,
  output logic                    RD_EN,
  output logic [ADDR_W-1:0]       RD_ADDR,
  input  logic [16*LANES-1:0]     RD_DATA,
  output logic [8*TRANS_NUM-1:0]  DUTY,
  output logic [8*TRANS_NUM-1:0]  PHASE,
  output logic                    BUSY,
  output logic                    UPDATE,
  output logic [1:0]              DBG_STATE
);

  localparam int SW   = (S > 0) ? S : 1;
  localparam int CH_W = 8 * TRANS_NUM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_last;
  logic [IDX_W-1:0]  load_idx;
  logic              en_last;
  logic              pending;
  logic              mode_r;
  logic [SW-1:0]     word;
  logic [RD_LATENCY-1:0] pv;
  logic [SW-1:0]     pw [RD_LATENCY];
  logic [CH_W-1:0]   sh_duty;
  logic [CH_W-1:0]   sh_phase;
  logic              idx_chg;
  logic              trigger;
  logic              last_cap;
  logic              abort;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [IDX_W-1:0] idx,
                                                input logic [SW-1:0] w);
    mk_addr = (ADDR_W'(idx) << S) | ADDR_W'(w);
  endfunction

  assign idx_chg   = (SEQ_IDX != idx_last);
  assign trigger   = ENABLE && (idx_chg || !en_last);
  assign last_cap  = pv[RD_LATENCY-1] && (pw[RD_LATENCY-1] == SW'(W - 1));
  assign abort     = (state != IDLE) && !ENABLE;
  assign BUSY      = (state != IDLE);
  assign DBG_STATE = state;

  // Read handshake: RD_EN high in cycle k issues RD_ADDR; RD_DATA is valid exactly
  // RD_LATENCY cycles later with no backpressure, tracked by the pv/pw tag pipeline.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pv       <= '0;
      sh_duty  <= '0;
      sh_phase <= '0;
      for (int j = 0; j < RD_LATENCY; j++) pw[j] <= '0;
    end else begin
      if (abort) begin
        pv <= '0;
      end else begin
        pv[0] <= RD_EN;
        for (int j = 1; j < RD_LATENCY; j++) pv[j] <= pv[j-1];
      end
      pw[0] <= word;
      for (int j = 1; j < RD_LATENCY; j++) pw[j] <= pw[j-1];
      if (pv[RD_LATENCY-1]) begin
        for (int j = 0; j < W; j++) begin
          if (pw[RD_LATENCY-1] == SW'(j)) begin
            for (int i = 0; i < LANES; i++) begin
              if (j * LANES + i < TRANS_NUM) begin
                sh_duty[8*(j*LANES+i) +: 8]  <= RD_DATA[16*i+8 +: 8];
                sh_phase[8*(j*LANES+i) +: 8] <= RD_DATA[16*i +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx_last <= '0;
      en_last  <= 1'b0;
      load_idx <= '0;
      word     <= '0;
      pending  <= 1'b0;
      mode_r   <= 1'b0;
      RD_EN    <= 1'b0;
      RD_ADDR  <= '0;
      DUTY     <= '0;
      PHASE    <= '0;
      UPDATE   <= 1'b0;
    end else begin
      idx_last <= SEQ_IDX;
      en_last  <= ENABLE;
      UPDATE   <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        RD_EN   <= 1'b0;
        pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              load_idx <= SEQ_IDX;
              mode_r   <= MODE;
              word     <= '0;
              RD_EN    <= 1'b1;
              RD_ADDR  <= mk_addr(SEQ_IDX, '0);
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (idx_chg) pending <= 1'b1;
            if (word == SW'(W - 1)) begin
              RD_EN <= 1'b0;
              state <= DRAIN;
            end else begin
              word    <= word + SW'(1);
              RD_ADDR <= mk_addr(load_idx, word + SW'(1));
            end
          end
          DRAIN: begin
            if (idx_chg) pending <= 1'b1;
            if (last_cap) state <= COMMIT;
          end
          COMMIT: begin
            DUTY   <= mode_r ? {TRANS_NUM{DUTY_FIXED}} : sh_duty;
            PHASE  <= sh_phase;
            UPDATE <= 1'b1;
            // A reload requested during the load restarts straight from here.
            if (pending || idx_chg) begin
              pending  <= 1'b0;
              load_idx <= SEQ_IDX;
              mode_r   <= MODE;
              word     <= '0;
              RD_EN    <= 1'b1;
              RD_ADDR  <= mk_addr(SEQ_IDX, '0);
              state    <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_dp_loader.sv
// Bench for seq_dp_loader with 10 channels, 4 lanes, read latency 2 and a
// behavioural BRAM whose contents are a fixed function of address and lane.
module tb_seq_dp_loader;
  localparam int TN = 10;
  localparam int AW = 18;
  localparam int FW = 160;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic          MODE = 1'b0;
  logic [7:0]    DUTY_FIXED = 8'h80;
  logic [15:0]   SEQ_IDX = '0;
  logic          RD_EN;
  logic [AW-1:0] RD_ADDR;
  logic [63:0]   RD_DATA;
  logic [63:0]   bram_d1;
  logic [79:0]   DUTY;
  logic [79:0]   PHASE;
  logic          BUSY;
  logic          UPDATE;
  logic [1:0]    DBG_STATE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit addr_chk = 1'b0;

  logic [FW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [FW-1:0] prev_out = '0;
  logic [FW-1:0] cur_frame;
  logic [FW-1:0] ef;
  int            ec;

  seq_dp_loader #(.TRANS_NUM(TN), .LANES(4), .IDX_W(16), .RD_LATENCY(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .MODE(MODE),
    .DUTY_FIXED(DUTY_FIXED), .SEQ_IDX(SEQ_IDX), .RD_EN(RD_EN),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .DUTY(DUTY), .PHASE(PHASE),
    .BUSY(BUSY), .UPDATE(UPDATE), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic logic [7:0] b_duty(input int a, input int i);
    return 8'(a * 4 + i + 64);
  endfunction

  function automatic logic [7:0] b_phase(input int a, input int i);
    return 8'(a * 7 + i * 3 + 1);
  endfunction

  function automatic logic [63:0] b_word(input int a);
    logic [63:0] w;
    for (int i = 0; i < 4; i++) w[16*i +: 16] = {b_duty(a, i), b_phase(a, i)};
    return w;
  endfunction

  // BRAM with two cycles of read latency
  always @(posedge CLK) begin
    bram_d1 <= b_word(int'(RD_ADDR));
    RD_DATA <= bram_d1;
  end

  function automatic logic [FW-1:0] frame(input int idx, input bit mode, input logic [7:0] fix);
    logic [79:0] d;
    logic [79:0] p;
    for (int c = 0; c < TN; c++) begin
      d[8*c +: 8] = mode ? fix : b_duty(idx * 4 + c / 4, c % 4);
      p[8*c +: 8] = b_phase(idx * 4 + c / 4, c % 4);
    end
    return {d, p};
  endfunction

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_load(input int idx, input bit mode, input int upd_cyc);
    exp_q.push_back(frame(idx, mode, 8'h80));
    exp_cyc_q.push_back(upd_cyc);
    for (int w = 0; w < 3; w++) exp_addr_q.push_back(AW'(idx * 4 + w));
  endtask

  task automatic wait_drained(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || BUSY) && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || BUSY) begin
      n_err++;
      $display("FAIL drain_timeout: %0d frames outstanding, BUSY=%0b, required 0 and 0", exp_q.size(), BUSY);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RST_N) begin
      if (UPDATE) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_update: UPDATE=1 at cycle %0d, required 0", cyc);
        end else begin
          ef = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("frame", {DUTY, PHASE}, ef);
          chk("update_cycle", FW'(cyc), FW'(ec));
        end
      end else begin
        chk("hold_between_updates", {DUTY, PHASE}, prev_out);
      end
      if (RD_EN && addr_chk) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_read: RD_EN=1 addr %0d, required RD_EN=0", RD_ADDR);
        end else begin
          chk("rd_addr", FW'(RD_ADDR), FW'(exp_addr_q.pop_front()));
        end
      end
    end
    prev_out = {DUTY, PHASE};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_frame", {DUTY, PHASE}, '0);
    chk("reset_ctrl", FW'({BUSY, UPDATE, RD_EN, RD_ADDR, DBG_STATE}), '0);
    RST_N = 1'b1;
    tick(2);

    // raw load of index 5
    addr_chk = 1'b1;
    ENABLE = 1'b1; SEQ_IDX = 16'd5; MODE = 1'b0;
    expect_load(5, 1'b0, cyc + 7);
    tick(2);
    chk("busy_in_load", FW'(BUSY), FW'(1));
    wait_drained(40);
    chk("ch9_duty", FW'(DUTY[79:72]), FW'(8'h99));
    chk("ch9_phase", FW'(PHASE[79:72]), FW'(8'h9E));
    chk("ch0_duty", FW'(DUTY[7:0]), FW'(8'h90));
    chk("ch0_phase", FW'(PHASE[7:0]), FW'(8'h8D));

    // phase-only load of index 9
    MODE = 1'b1; SEQ_IDX = 16'd9;
    expect_load(9, 1'b1, cyc + 7);
    wait_drained(40);
    chk("fixed_duty_ch3", FW'(DUTY[31:24]), FW'(8'h80));

    // 5 -> 6 -> 7 during fetch, MODE flipped mid-load
    MODE = 1'b0; SEQ_IDX = 16'd5;
    expect_load(5, 1'b0, cyc + 7);
    expect_load(7, 1'b1, cyc + 13);
    tick();
    SEQ_IDX = 16'd6; MODE = 1'b1;
    tick();
    SEQ_IDX = 16'd7;
    tick(5);
    chk("busy_through_reload", FW'(BUSY), FW'(1));
    wait_drained(60);

    // ENABLE dropped in DRAIN
    cur_frame = frame(7, 1'b1, 8'h80);
    MODE = 1'b0; SEQ_IDX = 16'd3;
    for (int w = 0; w < 3; w++) exp_addr_q.push_back(AW'(12 + w));
    tick(5);
    chk("busy_in_drain", FW'(BUSY), FW'(1));
    ENABLE = 1'b0;
    tick();
    chk("abort_busy", FW'(BUSY), FW'(0));
    tick(8);
    chk("abort_hold", {DUTY, PHASE}, cur_frame);

    // reset in FETCH, then reload on ENABLE rise
    addr_chk = 1'b0;
    ENABLE = 1'b1; SEQ_IDX = 16'd12;
    tick(2);
    #1 RST_N = 1'b0;
    #1;
    chk("async_rst_frame", {DUTY, PHASE}, '0);
    chk("async_rst_ctrl", FW'({BUSY, UPDATE, RD_EN, RD_ADDR}), '0);
    ENABLE = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(2);
    chk("idle_after_rst", FW'(BUSY), FW'(0));
    addr_chk = 1'b1;
    ENABLE = 1'b1;
    expect_load(12, 1'b0, cyc + 7);
    wait_drained(40);

    tick(5);
    n_cmp++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d frames %0d reads pending, required 0 and 0", exp_q.size(), exp_addr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
